// File: rtl/jk_bist_checker.sv
// Built-in self test for an external JK flip-flop: drives a fixed J/K pattern
// sequence, tracks the expected q in a reference model and counts mismatching cycles.
module jk_bist_checker #(
  parameter int HOLD_CYCLES = 5,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dut_q,
  input  logic             dut_qbar,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       phase
);

  localparam int HW = 6;
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_CHECK, S_DONE} state_t;

  state_t          state, nstate;
  logic [HW-1:0]   hold_cnt;
  logic [1:0]      ph;
  logic            exp_q;
  logic            chk_valid;
  logic            hold_wrap;
  logic            mismatch;

  // {j,k} for each run phase: set, reset, hold, toggle
  function automatic logic [1:0] pat_jk(input logic [1:0] p);
    case (p)
      2'd0:    pat_jk = 2'b10;
      2'd1:    pat_jk = 2'b01;
      2'd2:    pat_jk = 2'b00;
      default: pat_jk = 2'b11;
    endcase
  endfunction

  function automatic logic jk_next(input logic q, input logic jj, input logic kk);
    case ({jj, kk})
      2'b10:   jk_next = 1'b1;
      2'b01:   jk_next = 1'b0;
      2'b00:   jk_next = q;
      default: jk_next = ~q;
    endcase
  endfunction

  assign hold_wrap = (hold_cnt == HOLD_LAST);
  assign mismatch  = (dut_q != exp_q) || (dut_qbar != ~exp_q);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE, S_DONE: if (start) nstate = S_INIT;
      S_INIT:         nstate = S_RUN;
      S_RUN:          if (hold_wrap && ph == 2'd3) nstate = S_CHECK;
      S_CHECK:        nstate = S_DONE;
      default:        nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      j         <= 1'b0;
      k         <= 1'b0;
      hold_cnt  <= '0;
      ph        <= '0;
      exp_q     <= 1'b0;
      chk_valid <= 1'b0;
      err_count <= '0;
    end else begin
      // compare uses the model value before this edge's update
      if (chk_valid && mismatch && err_count != ERR_MAX)
        err_count <= err_count + 1'b1;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            j         <= 1'b0;
            k         <= 1'b1;
            hold_cnt  <= '0;
            ph        <= '0;
            err_count <= '0;
          end
        end
        S_INIT: begin
          {j, k}    <= pat_jk(2'd0);
          exp_q     <= 1'b0;
          chk_valid <= 1'b1;
          hold_cnt  <= '0;
          ph        <= '0;
        end
        S_RUN: begin
          exp_q <= jk_next(exp_q, j, k);
          if (hold_wrap) begin
            hold_cnt <= '0;
            if (ph == 2'd3) begin
              {j, k} <= 2'b00;
            end else begin
              ph     <= ph + 2'd1;
              {j, k} <= pat_jk(ph + 2'd1);
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          {j, k}    <= 2'b00;
          chk_valid <= 1'b0;
        end
        default: begin
          {j, k}    <= 2'b00;
          chk_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = (state == S_INIT) || (state == S_RUN) || (state == S_CHECK);
  assign done  = (state == S_DONE);
  assign pass  = done && (err_count == '0);
  assign phase = (state == S_RUN) ? ph : 2'd0;

endmodule

// File: tb/tb_jk_bist_checker.sv
// Bench for jk_bist_checker: an ideal or faulty JK plant feeds the checker while a
// sequence-level model predicts j/k, phase, busy/done and error counts.
module tb_jk_bist_checker;

  localparam int H = 5;
  localparam int N = 4*H + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       j, k, busy, done, pass;
  logic [7:0] err;
  logic [1:0] phase;
  logic       j2, k2, busy2, done2, pass2;
  logic [2:0] err2;
  logic [1:0] phase2;

  logic plant_q = 1'b0;
  logic fq = 1'b0, fqb = 1'b1, fq2 = 1'b0;
  logic dq, dqb;
  int   mode = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  jk_bist_checker #(.HOLD_CYCLES(H), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .dut_q(dq), .dut_qbar(dqb),
    .j(j), .k(k), .busy(busy), .done(done), .pass(pass),
    .err_count(err), .phase(phase));

  // narrow counter fed q==qbar so every compare fails
  jk_bist_checker #(.HOLD_CYCLES(H), .ERR_W(3)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .dut_q(fq2), .dut_qbar(fq2),
    .j(j2), .k(k2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .phase(phase2));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    case ({j, k})
      2'b10:   plant_q <= 1'b1;
      2'b01:   plant_q <= 1'b0;
      2'b11:   plant_q <= ~plant_q;
      default: plant_q <= plant_q;
    endcase
  end

  assign dq  = (mode == 0) ? plant_q  : fq;
  assign dqb = (mode == 0) ? ~plant_q : fqb;

  // expected {j,k} in force after the n-th edge following the start edge
  function automatic logic [1:0] seq_jk(input int n);
    logic [1:0] tbl [4];
    tbl[0] = 2'b10; tbl[1] = 2'b01; tbl[2] = 2'b00; tbl[3] = 2'b11;
    if (n == 0)                 return 2'b01;
    else if (n >= 1 && n <= 4*H) return tbl[(n-1)/H];
    else                        return 2'b00;
  endfunction

  function automatic logic jk_rule(input logic q, input logic [1:0] jk);
    case (jk)
      2'b10:   return 1'b1;
      2'b01:   return 1'b0;
      2'b00:   return q;
      default: return ~q;
    endcase
  endfunction

  task automatic set_feed();
    case (mode)
      1: begin fq = 1'b0; fqb = 1'b1; end
      2: begin fq = 1'b0; fqb = 1'b0; end
      3: begin fq = 1'($urandom); fqb = 1'($urandom); end
      default: ;
    endcase
    fq2 = 1'($urandom);
  endtask

  // Full sequence from a start pulse; start_at re-pulses start at that edge index.
  task automatic run_seq(input int mode_i, input int start_at, output int errs);
    int   e, e2, exp_ph;
    logic mq, sq, sqb;
    logic [1:0] ejk;
    e = 0; e2 = 0; mq = 1'b0;
    mode = mode_i;
    @(negedge clk);
    set_feed();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({j, k} !== 2'b01 || busy !== 1'b1 || done !== 1'b0 || err !== 8'd0) begin
      n_fail++;
      $display("FAIL init: jk=%b busy=%b done=%b err=%0d, want jk=01 busy=1 done=0 err=0", {j,k}, busy, done, err);
    end
    for (int n = 1; n <= N; n++) begin
      start = (n == start_at);
      set_feed();
      sq  = (mode == 0) ? plant_q  : fq;
      sqb = (mode == 0) ? ~plant_q : fqb;
      @(posedge clk);
      if (n >= 2) begin
        if (sq !== mq || sqb !== ~mq) e++;
        e2++;
      end
      mq = jk_rule(mq, seq_jk(n-1));
      @(negedge clk);
      start = 1'b0;
      ejk    = seq_jk(n);
      exp_ph = (n >= 1 && n <= 4*H) ? (n-1)/H : 0;
      n_checks++;
      if ({j, k} !== ejk || busy !== (n < N) || done !== (n == N) || phase !== 2'(exp_ph)) begin
        n_fail++;
        $display("FAIL seq n=%0d: jk=%b busy=%b done=%b phase=%0d, want jk=%b busy=%0d done=%0d phase=%0d",
                 n, {j,k}, busy, done, phase, ejk, (n < N), (n == N), exp_ph);
      end
      n_checks++;
      if (err !== 8'((e > 255) ? 255 : e) || err2 !== 3'((e2 > 7) ? 7 : e2)) begin
        n_fail++;
        $display("FAIL errcnt n=%0d: err=%0d err_sat=%0d, want %0d and %0d",
                 n, err, err2, (e > 255) ? 255 : e, (e2 > 7) ? 7 : e2);
      end
    end
    n_checks++;
    if (pass !== (e == 0)) begin
      n_fail++;
      $display("FAIL pass: got %b want %0d", pass, (e == 0));
    end
    errs = e;
  endtask

  task automatic check_reset_vals(input string tag);
    n_checks++;
    if ({j, k, busy, done, pass} !== 5'b0 || err !== 8'd0 || phase !== 2'd0 ||
        err2 !== 3'd0 || busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: j=%b k=%b busy=%b done=%b pass=%b err=%0d phase=%0d err_sat=%0d, want all 0",
               tag, j, k, busy, done, pass, err, phase, err2);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
  endtask

  task automatic test_ideal();
    int e;
    run_seq(0, -1, e);
    n_checks++;
    if (err !== 8'd0 || pass !== 1'b1 || err2 !== 3'd7) begin
      n_fail++;
      $display("FAIL ideal: err=%0d pass=%b err_sat=%0d, want 0 1 7", err, pass, err2);
    end
  endtask

  task automatic test_stuck_q0();
    int e;
    run_seq(1, -1, e);
    n_checks++;
    if (err !== 8'd8 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_q0: err=%0d pass=%b, want 8 0", err, pass);
    end
  endtask

  task automatic test_both_zero();
    int e;
    run_seq(2, -1, e);
    n_checks++;
    if (err !== 8'd21 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL both_zero: err=%0d pass=%b, want 21 0", err, pass);
    end
  endtask

  task automatic test_random();
    int e;
    for (int r = 0; r < 4; r++) run_seq(3, -1, e);
  endtask

  task automatic test_start_during_run();
    int e;
    run_seq(0, 10, e);
    n_checks++;
    if (pass !== 1'b1) begin
      n_fail++;
      $display("FAIL start_in_run: pass=%b want 1", pass);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    run_seq(2, -1, e);
    run_seq(0, -1, e);
    n_checks++;
    if (err !== 8'd0 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back: err=%0d pass=%b, want 0 1", err, pass);
    end
  endtask

  task automatic test_rst_mid();
    int e;
    mode = 2;
    @(negedge clk);
    set_feed();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    n_checks++;
    if (phase !== 2'd2 || err === 8'd0) begin
      n_fail++;
      $display("FAIL pre_rst: phase=%0d err=%0d, want phase 2 and err nonzero", phase, err);
    end
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_mid");
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_idle");
    run_seq(0, -1, e);
    n_checks++;
    if (pass !== 1'b1 || err !== 8'd0) begin
      n_fail++;
      $display("FAIL after_rst: pass=%b err=%0d, want 1 0", pass, err);
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_stuck_q0();
    test_both_zero();
    test_random();
    test_start_during_run();
    test_back_to_back();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
